bless_ni: RTL
=============

Name: bless_ni

Overview:
- Node-side network interface for the bufferless BLESS router.
- Injection path: takes whole packets from the core, splits them into flits and drives them onto the router's local input port.
- Ejection path: takes flits from the router's local output port and rebuilds packets; flits may arrive out of order because of deflection.
- All-zero flit word = empty slot, same encoding as the router ports.

Parameters:
- PKT_ID_W, 8, packet-id field width
- FLIT_ID_W, 2, flit-id field width
- TIME_W, 8, timestamp field width and width of the free-running cycle counter
- COORD_W, 2, width of each of Xdst and Ydst
- PAYLOAD_W, 32, payload bits per flit
- NFLIT, 4, flits per packet; must be ≤ 2^FLIT_ID_W
- REASM_SLOTS, 4, reassembly buffer entries
- MY_X, 0, this node's X coordinate
- MY_Y, 0, this node's Y coordinate

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- pkt_in_valid  in  1  core offers a packet
- pkt_in_ready  out  1  NI accepts the packet
- pkt_in_dst_x  in  COORD_W  destination X
- pkt_in_dst_y  in  COORD_W  destination Y
- pkt_in_data  in  NFLIT*PAYLOAD_W  packet payload; flit i takes bits [i*PAYLOAD_W +: PAYLOAD_W]
- inj_ok  in  1  router has a free output this cycle; injection allowed
- flit_out  out  FLIT_W  to router local input; FLIT_W = PKT_ID_W+FLIT_ID_W+TIME_W+2*COORD_W+PAYLOAD_W
- flit_in  in  FLIT_W  from router local output
- pkt_out_valid  out  1  reassembled packet available
- pkt_out_ready  in  1  core takes the packet
- pkt_out_id  out  PKT_ID_W  id of the delivered packet
- pkt_out_data  out  NFLIT*PAYLOAD_W  reassembled payload
- err_overflow  out  1  sticky: flit dropped because no reassembly slot was free
- err_misroute  out  1  sticky: flit arrived whose destination is not this node
- lat_valid  out  1  latency sample valid (optional feature)
- lat_value  out  TIME_W  latency sample (optional feature)

Behaviour:
- Flit field order, MSB to LSB: {PktId, FlitId, Time, Xdst, Ydst, payload}.
- Reset values: all outputs 0. Cycle counter resets to 0. Next-id counter resets to 1. Reassembly slots are cleared. Injection FSM goes to IDLE.
- Reset asserted mid-operation: the in-flight packet and any partial reassemblies are abandoned; flit_out goes to 0 immediately (asynchronous).
- Cycle counter: free-running, TIME_W bits, wraps to 0.
- PktId counter:
  - advances on each accepted packet;
  - sequence 1, 2, …, 2^PKT_ID_W−1, then back to 1; 0 is never issued, so no flit can be all-zero.
- Injection FSM:
  - IDLE: pkt_in_ready=1. On valid&ready, latch dst, data, Time=cycle counter and PktId; set idx=0; go to SEND.
  - SEND: pkt_in_ready=0.
    - Each cycle with inj_ok=1, register flit idx onto flit_out and increment idx.
    - Each cycle with inj_ok=0, register 0 onto flit_out.
    - After flit NFLIT−1 is sent, go to IDLE.
  - flit_out is registered and equals 0 whenever no flit is being sent.
  - Timing: packet accepted at edge t, inj_ok high from then on → flit 0 visible after edge t+1, remaining flits on consecutive cycles. One IDLE cycle between packets.
  - All flits of a packet carry the same Time value.
- Ejection input: flit_in is registered once. A registered word ≠ 0 is a valid flit.
- Misroute: if a valid flit's Xdst≠MY_X or Ydst≠MY_Y, drop it and set err_misroute.
- Reassembly, on a valid flit:
  - If a slot matches its PktId: set mask[FlitId] and write the payload. A duplicate flit overwrites silently.
  - Otherwise allocate the lowest-index free slot.
  - If no slot is free: drop the flit and set err_overflow.
- A slot is complete when all mask bits are set. Output presents the lowest-index complete slot: pkt_out_valid, pkt_out_id and pkt_out_data are registered and held stable until pkt_out_ready.
- The slot is freed on the valid&ready handshake. A slot freed in a cycle cannot be reallocated until the next cycle.
- Flit arriving while pkt_out is stalled: ejection still accepts it into other slots, because the router cannot be backpressured.
- Error flags stay set until reset.

Optional Feature:
- Macro BLESS_NI_LATENCY_EN.
- Defined: on each pkt_out handshake, lat_valid=1 for one cycle and lat_value = (cycle counter − slot Time) mod 2^TIME_W. Each slot stores its packet's Time.
- Undefined: lat_valid and lat_value are tied to 0, and no Time storage is built.

Decomposition:
- Shared package holds: the field-width constants, FLIT_W, field position constants, the flit struct/typedef, and the injection FSM state enum.
- One natural sub-module: bless_ni_reasm, the slot table with match/allocate/complete/output-select logic.
- Injection FSM and counters stay in the top level.

Test Plan:
- Test-bench configuration for all cases: MY_X=1, MY_Y=2.
- Reset; send packet dst(3,0), data 0x44444444_33333333_22222222_11111111; inj_ok=1 → four flits on consecutive cycles, PktId=1, FlitId 0..3, payloads 0x11111111..0x44444444, identical Time.
- Same packet with inj_ok pattern 1,0,1,0,1,0,1 → flit_out=0 on the 0 cycles, flits still in order 0..3, pkt_in_ready low until one cycle after flit 3.
- Accept 256 packets → packet 255 carries PktId 255, packet 256 carries PktId 1, never 0.
- Eject PktId 7, dst(1,2), FlitIds 2,0,3,1 with gaps, pkt_out_ready=1 → single pkt_out_valid with correct data and pkt_out_id=7. With BLESS_NI_LATENCY_EN: lat_value = cycle counter − Time.
- Five partial packets (ids 1..5, one flit each) → id 5 dropped, err_overflow=1 and held through a later successful packet.
- Flit dst(0,0) → err_misroute=1, pkt_out_valid stays 0.

Source files
------------

// File: rtl/bless_ni_pkg.sv
// Shared field widths, flit layout and injection FSM encoding for the BLESS network interface.
package bless_ni_pkg;

  localparam int PKT_ID_W    = 8;
  localparam int FLIT_ID_W   = 2;
  localparam int TIME_W      = 8;
  localparam int COORD_W     = 2;
  localparam int PAYLOAD_W   = 32;
  localparam int NFLIT       = 4;
  localparam int REASM_SLOTS = 4;

  localparam int FLIT_W = PKT_ID_W + FLIT_ID_W + TIME_W + 2*COORD_W + PAYLOAD_W;

  // Bit positions, MSB to LSB: {PktId, FlitId, Time, Xdst, Ydst, payload}
  localparam int PAY_LSB  = 0;
  localparam int Y_LSB    = PAYLOAD_W;
  localparam int X_LSB    = Y_LSB + COORD_W;
  localparam int TIME_LSB = X_LSB + COORD_W;
  localparam int FID_LSB  = TIME_LSB + TIME_W;
  localparam int PID_LSB  = FID_LSB + FLIT_ID_W;

  typedef struct packed {
    logic [PKT_ID_W-1:0]  pkt_id;
    logic [FLIT_ID_W-1:0] flit_id;
    logic [TIME_W-1:0]    tstamp;
    logic [COORD_W-1:0]   x_dst;
    logic [COORD_W-1:0]   y_dst;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } inj_state_t;

endpackage

// File: rtl/bless_ni_reasm.sv
// Reassembly slot table: matches flits to packets by PktId, allocates slots, presents completed packets.
// Slot timestamps are built only with BLESS_NI_LATENCY_EN.
module bless_ni_reasm #(
`ifdef BLESS_NI_LATENCY_EN
  parameter int TIME_W      = 8,
`endif
  parameter int PKT_ID_W    = 8,
  parameter int FLIT_ID_W   = 2,
  parameter int PAYLOAD_W   = 32,
  parameter int NFLIT       = 4,
  parameter int REASM_SLOTS = 4
) (
`ifdef BLESS_NI_LATENCY_EN
  input  logic [TIME_W-1:0]          i_time,
  output logic [TIME_W-1:0]          o_time,
`endif
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_vld,
  input  logic [PKT_ID_W-1:0]        i_pid,
  input  logic [FLIT_ID_W-1:0]       i_fid,
  input  logic [PAYLOAD_W-1:0]       i_pay,
  input  logic                       i_out_ready,
  output logic                       o_out_valid,
  output logic [PKT_ID_W-1:0]        o_out_id,
  output logic [NFLIT*PAYLOAD_W-1:0] o_out_data,
  output logic                       o_drop
);

  localparam int SW = (REASM_SLOTS > 1) ? $clog2(REASM_SLOTS) : 1;

  logic [REASM_SLOTS-1:0]     r_busy;
  logic [PKT_ID_W-1:0]        r_id   [REASM_SLOTS];
  logic [NFLIT-1:0]           r_mask [REASM_SLOTS];
  logic [NFLIT*PAYLOAD_W-1:0] r_data [REASM_SLOTS];
  logic                       r_ov;
  logic [SW-1:0]              r_osel;
  logic [PKT_ID_W-1:0]        r_oid;
  logic [NFLIT*PAYLOAD_W-1:0] r_odata;

  logic          w_hit, w_free, w_cpl;
  logic [SW-1:0] w_hit_idx, w_free_idx, w_cpl_idx, w_wslot;
  logic          w_wr, w_write, w_hs;
  logic [NFLIT-1:0] w_onehot;

  // Descending scan so the lowest matching index is the one that sticks
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    w_cpl      = 1'b0;
    w_cpl_idx  = '0;
    for (int s = REASM_SLOTS-1; s >= 0; s--) begin
      if (r_busy[s] && (r_id[s] == i_pid)) begin
        w_hit     = 1'b1;
        w_hit_idx = SW'(s);
      end
      if (!r_busy[s]) begin
        w_free     = 1'b1;
        w_free_idx = SW'(s);
      end
      if (r_busy[s] && (&r_mask[s])) begin
        w_cpl     = 1'b1;
        w_cpl_idx = SW'(s);
      end
    end
  end

  assign w_wr     = i_vld && (int'(i_fid) < NFLIT);
  assign w_write  = w_wr && (w_hit || w_free);
  assign w_wslot  = w_hit ? w_hit_idx : w_free_idx;
  assign w_onehot = NFLIT'(1) << i_fid;
  assign w_hs     = r_ov && i_out_ready;
  assign o_drop   = w_wr && !w_hit && !w_free;

  // A slot freed on the handshake still reads busy this cycle, so it is not reallocated until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= '0;
      r_ov    <= 1'b0;
      r_osel  <= '0;
      r_oid   <= '0;
      r_odata <= '0;
      for (int s = 0; s < REASM_SLOTS; s++) begin
        r_id[s]   <= '0;
        r_mask[s] <= '0;
      end
    end else begin
      if (w_write) begin
        r_busy[w_wslot] <= 1'b1;
        r_id[w_wslot]   <= i_pid;
        r_mask[w_wslot] <= (w_hit ? r_mask[w_wslot] : '0) | w_onehot;
      end
      if (w_hs) begin
        r_busy[r_osel] <= 1'b0;
        r_mask[r_osel] <= '0;
        r_ov           <= 1'b0;
      end else if (!r_ov && w_cpl) begin
        r_ov    <= 1'b1;
        r_osel  <= w_cpl_idx;
        r_oid   <= r_id[w_cpl_idx];
        r_odata <= r_data[w_cpl_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_data[w_wslot][int'(i_fid)*PAYLOAD_W +: PAYLOAD_W] <= i_pay;
    end
  end

`ifdef BLESS_NI_LATENCY_EN
  logic [TIME_W-1:0] r_time [REASM_SLOTS];
  logic [TIME_W-1:0] r_otime;

  always_ff @(posedge clk) begin
    if (w_write && !w_hit) begin
      r_time[w_wslot] <= i_time;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_otime <= '0;
    end else if (!w_hs && !r_ov && w_cpl) begin
      r_otime <= r_time[w_cpl_idx];
    end
  end

  assign o_time = r_otime;
`endif

  assign o_out_valid = r_ov;
  assign o_out_id    = r_oid;
  assign o_out_data  = r_odata;

endmodule

// File: rtl/bless_ni.sv
// BLESS node network interface: packet-to-flit injection FSM and out-of-order flit reassembly.
// Optional end-to-end latency sampling under BLESS_NI_LATENCY_EN.
module bless_ni #(
  parameter int PKT_ID_W    = 8,
  parameter int FLIT_ID_W   = 2,
  parameter int TIME_W      = 8,
  parameter int COORD_W     = 2,
  parameter int PAYLOAD_W   = 32,
  parameter int NFLIT       = 4,
  parameter int REASM_SLOTS = 4,
  parameter int MY_X        = 0,
  parameter int MY_Y        = 0,
  localparam int FLIT_W     = PKT_ID_W + FLIT_ID_W + TIME_W + 2*COORD_W + PAYLOAD_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pkt_in_valid,
  output logic                       pkt_in_ready,
  input  logic [COORD_W-1:0]         pkt_in_dst_x,
  input  logic [COORD_W-1:0]         pkt_in_dst_y,
  input  logic [NFLIT*PAYLOAD_W-1:0] pkt_in_data,
  input  logic                       inj_ok,
  output logic [FLIT_W-1:0]          flit_out,
  input  logic [FLIT_W-1:0]          flit_in,
  output logic                       pkt_out_valid,
  input  logic                       pkt_out_ready,
  output logic [PKT_ID_W-1:0]        pkt_out_id,
  output logic [NFLIT*PAYLOAD_W-1:0] pkt_out_data,
  output logic                       err_overflow,
  output logic                       err_misroute,
  output logic                       lat_valid,
  output logic [TIME_W-1:0]          lat_value
);
  import bless_ni_pkg::*;

  localparam int Y_POS  = PAYLOAD_W;
  localparam int X_POS  = Y_POS + COORD_W;
  localparam int T_POS  = X_POS + COORD_W;
  localparam int F_POS  = T_POS + TIME_W;
  localparam int P_POS  = F_POS + FLIT_ID_W;
  localparam logic [FLIT_ID_W-1:0] LAST_IDX = FLIT_ID_W'(NFLIT-1);
  localparam logic [PKT_ID_W-1:0]  ID_MAX   = '1;

  inj_state_t                 r_state;
  logic                       r_in_ready;
  logic [FLIT_ID_W-1:0]       r_idx;
  logic [TIME_W-1:0]          r_cycle;
  logic [PKT_ID_W-1:0]        r_next_id;
  logic [PKT_ID_W-1:0]        r_pid;
  logic [TIME_W-1:0]          r_time;
  logic [COORD_W-1:0]         r_dx, r_dy;
  logic [NFLIT*PAYLOAD_W-1:0] r_data;
  logic [FLIT_W-1:0]          r_flit_out;
  logic [FLIT_W-1:0]          r_flit_in;
  logic                       r_err_mis, r_err_ovf;

  logic                 w_accept;
  logic [PAYLOAD_W-1:0] w_pay;
  logic [FLIT_W-1:0]    w_flit;
  logic                 w_fvld, w_here, w_drop;

  assign w_accept = pkt_in_valid && r_in_ready && (r_state == ST_IDLE);
  assign w_pay    = r_data[int'(r_idx)*PAYLOAD_W +: PAYLOAD_W];
  assign w_flit   = {r_pid, r_idx, r_time, r_dx, r_dy, w_pay};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cycle <= '0;
    else       r_cycle <= r_cycle + 1'b1;
  end

  // Injection FSM; flit_out is zero on every cycle that does not carry a flit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_idx      <= '0;
      r_next_id  <= PKT_ID_W'(1);
      r_flit_out <= '0;
    end else begin
      r_flit_out <= '0;
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_state    <= ST_SEND;
            r_in_ready <= 1'b0;
            r_idx      <= '0;
            r_next_id  <= (r_next_id == ID_MAX) ? PKT_ID_W'(1) : r_next_id + 1'b1;
          end
        end
        ST_SEND: begin
          if (inj_ok) begin
            r_flit_out <= w_flit;
            r_idx      <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
              r_state    <= ST_IDLE;
              r_in_ready <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pid  <= r_next_id;
      r_time <= r_cycle;
      r_dx   <= pkt_in_dst_x;
      r_dy   <= pkt_in_dst_y;
      r_data <= pkt_in_data;
    end
  end

  // Ejection: one register stage; a nonzero word is a flit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_flit_in <= '0;
    else       r_flit_in <= flit_in;
  end

  assign w_fvld = |r_flit_in;
  assign w_here = (r_flit_in[X_POS +: COORD_W] == COORD_W'(MY_X)) &&
                  (r_flit_in[Y_POS +: COORD_W] == COORD_W'(MY_Y));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_mis <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      if (w_fvld && !w_here) r_err_mis <= 1'b1;
      if (w_drop)            r_err_ovf <= 1'b1;
    end
  end

`ifdef BLESS_NI_LATENCY_EN
  logic [TIME_W-1:0] w_hs_time;
  logic              r_lat_valid;
  logic [TIME_W-1:0] r_lat_value;
`else
  logic w_unused_time;
  assign w_unused_time = ^r_flit_in[T_POS +: TIME_W];
`endif

  bless_ni_reasm #(
`ifdef BLESS_NI_LATENCY_EN
    .TIME_W      (TIME_W),
`endif
    .PKT_ID_W    (PKT_ID_W),
    .FLIT_ID_W   (FLIT_ID_W),
    .PAYLOAD_W   (PAYLOAD_W),
    .NFLIT       (NFLIT),
    .REASM_SLOTS (REASM_SLOTS)
  ) u_reasm (
`ifdef BLESS_NI_LATENCY_EN
    .i_time      (r_flit_in[T_POS +: TIME_W]),
    .o_time      (w_hs_time),
`endif
    .clk         (clk),
    .rst         (reset),
    .i_vld       (w_fvld && w_here),
    .i_pid       (r_flit_in[P_POS +: PKT_ID_W]),
    .i_fid       (r_flit_in[F_POS +: FLIT_ID_W]),
    .i_pay       (r_flit_in[PAYLOAD_W-1:0]),
    .i_out_ready (pkt_out_ready),
    .o_out_valid (pkt_out_valid),
    .o_out_id    (pkt_out_id),
    .o_out_data  (pkt_out_data),
    .o_drop      (w_drop)
  );

`ifdef BLESS_NI_LATENCY_EN
  // Latency is taken against the counter value at the handshake edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lat_valid <= 1'b0;
      r_lat_value <= '0;
    end else begin
      r_lat_valid <= pkt_out_valid && pkt_out_ready;
      if (pkt_out_valid && pkt_out_ready) r_lat_value <= r_cycle - w_hs_time;
    end
  end

  assign lat_valid = r_lat_valid;
  assign lat_value = r_lat_value;
`else
  assign lat_valid = 1'b0;
  assign lat_value = '0;
`endif

  assign pkt_in_ready = r_in_ready;
  assign flit_out     = r_flit_out;
  assign err_overflow = r_err_ovf;
  assign err_misroute = r_err_mis;

endmodule
